// File: rtl/rebnet_pkg.sv
// Purpose : shared definitions for the ReBNet processing-element blocks
//           (binarizer FSM state encoding and a constant-evaluable clog2).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package rebnet_pkg;

    // Binarizer FSM state codes; the PE controller decodes the same values.
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_LEVEL    = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;
    localparam logic [2:0] S_WAIT_LOW = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_FETCH    = S_FETCH,
        ST_LOAD     = S_LOAD,
        ST_LEVEL    = S_LEVEL,
        ST_WRITE    = S_WRITE,
        ST_DONE     = S_DONE,
        ST_WAIT_LOW = S_WAIT_LOW
    } bin_state_t;

    // Ceiling log2, usable in parameter expressions. clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res++;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_res_level_step.sv
// Purpose : one residual-binarization level: sign of the residual, then move
//           the residual toward zero by gamma.
// Latency : combinational. Backpressure: none.
// Ports   : r (signed residual), gamma (unsigned scale) -> sign_bit (1 = +1),
//           r_next (updated residual).
module pe_res_level_step #(
    parameter int ACC_W = 16,
    parameter int RES_W = 19
) (
    input  logic signed [RES_W-1:0] r,
    input  logic        [ACC_W-1:0] gamma,
    output logic                    sign_bit,
    output logic signed [RES_W-1:0] r_next
);

    logic signed [RES_W-1:0] gamma_ext;

    // Gamma is a magnitude, so it is zero-extended.
    assign gamma_ext = {{(RES_W-ACC_W){1'b0}}, gamma};

    // An exact-zero residual counts as +1.
    assign sign_bit = ~r[RES_W-1];
    assign r_next   = sign_bit ? (r - gamma_ext) : (r + gamma_ext);

endmodule

// File: rtl/pe_residual_binarizer.sv
// Purpose : per neuron, reads acc and threshold, runs LEVELS residual
//           binarization steps and writes LEVELS sign bits; pulses finish_all
//           when every neuron has been written.
// Latency : LEVELS+3 cycles per neuron; finish_all NUM_NEURONS*(LEVELS+3)+1
//           cycles after IDLE samples binarize_start.
// Backpressure: none; buffers are fixed-latency (read data 1 cycle after rd_en).
// Ports   : clk, rst (async, active-high); binarize_start / finish_all
//           handshake; gamma_flat scales; rd_addr/rd_en -> acc_rdata/thr_rdata;
//           out_we/out_addr/out_bits activation writes.
module pe_residual_binarizer
    import rebnet_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ACC_W       = 16,
    parameter int LEVELS      = 2,
    parameter int ADDR_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    binarize_start,
    output logic                    finish_all,
    input  logic [LEVELS*ACC_W-1:0] gamma_flat,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic                    rd_en,
    input  logic [ACC_W-1:0]        acc_rdata,
    input  logic [ACC_W-1:0]        thr_rdata,
    output logic                    out_we,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [LEVELS-1:0]       out_bits
);

    // Headroom: one bit for acc - thr, plus enough for LEVELS gamma steps.
    localparam int RES_W = ACC_W + 1 + clog2(LEVELS + 1);
    localparam int LVL_W = (LEVELS > 1) ? clog2(LEVELS) : 1;

    bin_state_t              state;
    bin_state_t              state_nxt;
    logic [ADDR_W-1:0]       idx;
    logic [LVL_W-1:0]        lvl;
    logic signed [RES_W-1:0] r;
    logic [LEVELS-1:0]       b;

    logic signed [RES_W-1:0] acc_ext;
    logic signed [RES_W-1:0] thr_ext;
    logic [ACC_W-1:0]        gamma_cur;
    logic                    step_sign;
    logic signed [RES_W-1:0] step_r;
    logic [LEVELS-1:0]       b_shift;
    logic                    last_lvl;
    logic                    last_idx;

    assign acc_ext  = {{(RES_W-ACC_W){acc_rdata[ACC_W-1]}}, acc_rdata};
    assign thr_ext  = {{(RES_W-ACC_W){thr_rdata[ACC_W-1]}}, thr_rdata};
    assign last_lvl = (lvl == LVL_W'(LEVELS - 1));
    assign last_idx = (idx == ADDR_W'(NUM_NEURONS - 1));

    // Gamma for the current level.
    always_comb begin
        gamma_cur = gamma_flat[ACC_W-1:0];
        for (int l = 0; l < LEVELS; l++) begin
            if (lvl == LVL_W'(l)) begin
                gamma_cur = gamma_flat[l*ACC_W +: ACC_W];
            end
        end
    end

    // Single level step shared by all levels.
    pe_res_level_step #(
        .ACC_W (ACC_W),
        .RES_W (RES_W)
    ) u_step (
        .r        (r),
        .gamma    (gamma_cur),
        .sign_bit (step_sign),
        .r_next   (step_r)
    );

    // Sign bits enter at the top and shift down, so after LEVELS steps
    // level 0 sits in bit 0. Written this way it also holds for LEVELS = 1.
    always_comb begin
        b_shift             = b >> 1;
        b_shift[LEVELS-1]   = step_sign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (binarize_start) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = ST_LEVEL;
            ST_LEVEL:    if (last_lvl) state_nxt = ST_WRITE;
            ST_WRITE:    state_nxt = last_idx ? ST_DONE : ST_FETCH;
            ST_DONE:     state_nxt = ST_WAIT_LOW;
            // A held request must not retrigger a run.
            ST_WAIT_LOW: if (!binarize_start) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            lvl <= '0;
            r   <= '0;
            b   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (binarize_start) idx <= '0;
                end
                ST_LOAD: begin
                    r   <= acc_ext - thr_ext;
                    lvl <= '0;
                end
                ST_LEVEL: begin
                    r   <= step_r;
                    b   <= b_shift;
                    lvl <= lvl + LVL_W'(1);
                end
                ST_WRITE: begin
                    if (!last_idx) idx <= idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state register, so a reset clears
    // them at once; addresses and data read as zero outside their strobe.
    assign rd_en      = (state == ST_FETCH);
    assign out_we     = (state == ST_WRITE);
    assign finish_all = (state == ST_DONE);
    assign rd_addr    = rd_en  ? idx : '0;
    assign out_addr   = out_we ? idx : '0;
    assign out_bits   = out_we ? b   : '0;

endmodule

// File: tb/tb_pe_residual_binarizer.sv
module tb_pe_residual_binarizer;

    logic        clk;
    logic        rst;
    logic        binarize_start;
    logic        finish_all;
    logic [31:0] gamma_flat;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [15:0] acc_rdata;
    logic [15:0] thr_rdata;
    logic        out_we;
    logic [3:0]  out_addr;
    logic [1:0]  out_bits;

    int n_cmp;
    int n_err;

    logic [15:0] acc_mem [4];
    logic [15:0] thr_mem [4];

    // Monitor state (written only by the monitor processes).
    int          cyc;
    logic [1:0]  wr_bits [4];
    int          wr_cyc  [4];
    int          wr_cnt;
    int          fin_cnt;
    int          fin_cyc;
    int          excl_viol;
    int          bad_addr;

    pe_residual_binarizer #(
        .NUM_NEURONS (4),
        .ACC_W       (16),
        .LEVELS      (2),
        .ADDR_W      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .binarize_start (binarize_start),
        .finish_all     (finish_all),
        .gamma_flat     (gamma_flat),
        .rd_addr        (rd_addr),
        .rd_en          (rd_en),
        .acc_rdata      (acc_rdata),
        .thr_rdata      (thr_rdata),
        .out_we         (out_we),
        .out_addr       (out_addr),
        .out_bits       (out_bits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Buffers with one cycle of read latency.
    initial begin
        acc_rdata = '0;
        thr_rdata = '0;
    end
    always @(posedge clk) begin
        if (rd_en) begin
            acc_rdata <= acc_mem[rd_addr[1:0]];
            thr_rdata <= thr_mem[rd_addr[1:0]];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_we) begin
            if (out_addr > 4'd3) begin
                bad_addr++;
            end else begin
                wr_bits[out_addr[1:0]] = out_bits;
                wr_cyc[out_addr[1:0]]  = cyc;
            end
            wr_cnt++;
        end
        if (finish_all) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if ((int'(out_we) + int'(rd_en) + int'(finish_all)) > 1) excl_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: two residual levels, bit l = sign of level l.
    function automatic logic [1:0] model(input logic [15:0] a, input logic [15:0] t,
                                         input logic [15:0] g0, input logic [15:0] g1);
        int         r;
        logic [1:0] bits;
        r       = int'($signed(a)) - int'($signed(t));
        bits[0] = (r >= 0);
        r       = bits[0] ? r - int'(g0) : r + int'(g0);
        bits[1] = (r >= 0);
        return bits;
    endfunction

    // Raise the request at a negedge and wait (bounded) for finish_all.
    // c0 is the cycle count from which relative event times are measured.
    task automatic run_pass(output int c0);
        int base;
        base = fin_cnt;
        c0   = cyc;
        binarize_start = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (fin_cnt != base) break;
        end
        chk("finish_seen", 32'(fin_cnt != base), 32'd1);
    endtask

    task automatic drop_start();
        binarize_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_finish"},   32'(finish_all), 32'd0);
        chk({tag, "_rd_en"},    32'(rd_en),      32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),    32'd0);
        chk({tag, "_out_we"},   32'(out_we),     32'd0);
        chk({tag, "_out_addr"}, 32'(out_addr),   32'd0);
        chk({tag, "_out_bits"}, 32'(out_bits),   32'd0);
    endtask

    logic [1:0] exp_bits [4];

    initial begin
        int c0;
        int wr0;
        int fin0;
        logic [15:0] g0;
        logic [15:0] g1;

        n_cmp = 0;
        n_err = 0;
        rst            = 1'b1;
        binarize_start = 1'b0;
        gamma_flat     = {16'd4, 16'd8};

        // Directed vectors: 10/0, -3/0, 5/5 (exact zero), -32768/32767.
        acc_mem[0] = 16'd10;   thr_mem[0] = 16'd0;
        acc_mem[1] = 16'hFFFD; thr_mem[1] = 16'd0;
        acc_mem[2] = 16'd5;    thr_mem[2] = 16'd5;
        acc_mem[3] = 16'h8000; thr_mem[3] = 16'h7FFF;
        exp_bits[0] = 2'b11;
        exp_bits[1] = 2'b10;
        exp_bits[2] = 2'b01;
        exp_bits[3] = 2'b00;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed values and timing with the request held high.
        wr0  = wr_cnt;
        fin0 = fin_cnt;
        run_pass(c0);
        chk("bits_acc10",   32'(wr_bits[0]), 32'(exp_bits[0]));
        chk("bits_accm3",   32'(wr_bits[1]), 32'(exp_bits[1]));
        chk("bits_zero",    32'(wr_bits[2]), 32'(exp_bits[2]));
        chk("bits_extreme", 32'(wr_bits[3]), 32'(exp_bits[3]));
        for (int i = 0; i < 4; i++) begin
            chk("we_cycle", 32'(wr_cyc[i] - c0), 32'(5 * (i + 1)));
        end
        chk("finish_cycle", 32'(fin_cyc - c0), 32'd21);
        chk("write_count",  32'(wr_cnt - wr0), 32'd4);
        repeat (30) @(negedge clk);
        chk("no_restart_fin", 32'(fin_cnt - fin0), 32'd1);
        chk("no_restart_we",  32'(wr_cnt - wr0),   32'd4);
        drop_start();

        // Reset during LEVEL of neuron 2 (relative cycle 13).
        wr0  = wr_cnt;
        fin0 = fin_cnt;
        c0   = cyc;
        binarize_start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cyc - c0 >= 13) break;
        end
        chk("rst_point", 32'(cyc - c0), 32'd13);
        rst            = 1'b1;
        binarize_start = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        chk("midrst_writes", 32'(wr_cnt - wr0),   32'd2);
        chk("midrst_fin",    32'(fin_cnt - fin0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr0 = wr_cnt;
        run_pass(c0);
        chk("rerun_writes", 32'(wr_cnt - wr0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rerun_bits",  32'(wr_bits[i]), 32'(exp_bits[i]));
            chk("rerun_cycle", 32'(wr_cyc[i] - c0), 32'(5 * (i + 1)));
        end
        drop_start();

        // Random operands and gammas against the reference model.
        for (int run = 0; run < 1000; run++) begin
            g0 = 16'($urandom);
            g1 = 16'($urandom);
            if (run % 10 == 0) g1 = 16'd0;
            gamma_flat = {g1, g0};
            for (int i = 0; i < 4; i++) begin
                acc_mem[i]  = 16'($urandom);
                thr_mem[i]  = 16'($urandom);
                exp_bits[i] = model(acc_mem[i], thr_mem[i], g0, g1);
            end
            wr0 = wr_cnt;
            run_pass(c0);
            chk("rand_writes", 32'(wr_cnt - wr0), 32'd4);
            for (int i = 0; i < 4; i++) begin
                chk("rand_bits", 32'(wr_bits[i]), 32'(exp_bits[i]));
            end
            drop_start();
        end

        chk("strobe_excl", 32'(excl_viol), 32'd0);
        chk("addr_range",  32'(bad_addr),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
